// File: rtl/approx_nod_pipe.sv
// approx_nod_pipe: two-stage nearest-power-of-two rounder with an approximate low region.
// S1 captures leading-one position and round bit; S2 forms one-hot, index and zero flag.
module approx_nod_pipe #(
    parameter int WIDTH = 16,
    parameter int APPROX_BITS = 4,
    localparam int IW = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH:0]   data_o,
    output logic [IW-1:0]    index_o,
    output logic             zero_o,
    output logic             valid_o,
    input  logic             ready_i
);
    localparam logic [WIDTH-1:0] LIM = WIDTH'(1) << APPROX_BITS;
    localparam logic [WIDTH-1:0] THR = WIDTH'(1) << (APPROX_BITS - 2);
    logic [WIDTH-1:0] d_ext;
    logic [IW-1:0] lead_m, s1_m, s2_idx;
    logic lead_r, approx_sel, s1_r, s1_zero, s1_valid, s2_adv;
    assign d_ext = {data_i[WIDTH-2:0], 1'b0};
    always_comb begin
        lead_m = '0;
        lead_r = 1'b0;
        for (int i = 0; i < WIDTH; i++)
            if (data_i[i]) begin
                lead_m = IW'(i);
                lead_r = d_ext[i];
            end
    end
    assign approx_sel = mode_i && (data_i < LIM);
    assign s2_adv = ~valid_o | ready_i;
    assign ready_o = ~rst_i & (~s1_valid | s2_adv);
    assign s2_idx = s1_zero ? '0 : s1_m + IW'(s1_r);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_m <= '0;
            s1_r <= 1'b0;
            s1_zero <= 1'b0;
        end else if (ready_o) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_m <= approx_sel ? ((data_i <= THR) ? IW'(APPROX_BITS / 2 - 1) : IW'(APPROX_BITS - 1)) : lead_m;
                s1_r <= ~approx_sel & lead_r;
                s1_zero <= (data_i == '0);
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o <= '0;
            index_o <= '0;
            zero_o <= 1'b0;
        end else if (s2_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                data_o <= s1_zero ? '0 : (WIDTH + 1)'(1) << s2_idx;
                index_o <= s2_idx;
                zero_o <= s1_zero;
            end
        end
    end
endmodule
